// File: rtl/maze_pkg.sv
// maze_pkg: shared types and constants for the maze DFS controller.
package maze_pkg;

    localparam int MAZE_COORD_W = 4;

    typedef enum logic [3:0] {
        S_IDLE,
        S_CHK0,
        S_CHK0W,
        S_TEST,
        S_WAIT,
        S_ADV,
        S_BACK,
        S_DONE,
        S_FAIL
    } state_t;

    localparam logic [1:0] DIR_R = 2'd0;
    localparam logic [1:0] DIR_D = 2'd1;
    localparam logic [1:0] DIR_L = 2'd2;
    localparam logic [1:0] DIR_U = 2'd3;

endpackage

// File: rtl/maze_nbr_calc.sv
// maze_nbr_calc: neighbour coordinate for a cell and direction, with an
// in-bounds flag. Edges never wrap.
module maze_nbr_calc
    import maze_pkg::*;
#(
    parameter int COORD_W = MAZE_COORD_W
)(
    input  logic [COORD_W-1:0] cur_x,
    input  logic [COORD_W-1:0] cur_y,
    input  logic [1:0]         dir,
    output logic [COORD_W-1:0] nbr_x,
    output logic [COORD_W-1:0] nbr_y,
    output logic               in_bounds
);

    localparam logic [COORD_W-1:0] MAX_C = '1;

    // step one cell in the requested direction, flag edge crossings
    always_comb begin
        nbr_x     = cur_x;
        nbr_y     = cur_y;
        in_bounds = 1'b0;
        case (dir)
            DIR_R: begin
                nbr_x     = cur_x + 1'b1;
                in_bounds = (cur_x != MAX_C);
            end
            DIR_D: begin
                nbr_y     = cur_y + 1'b1;
                in_bounds = (cur_y != MAX_C);
            end
            DIR_L: begin
                nbr_x     = cur_x - 1'b1;
                in_bounds = (cur_x != '0);
            end
            DIR_U: begin
                nbr_y     = cur_y - 1'b1;
                in_bounds = (cur_y != '0);
            end
        endcase
    end

endmodule

// File: rtl/maze_dfs_ctrl.sv
// maze_dfs_ctrl: depth-first maze search sequencer. Drives an external
// coordinate stack and a 16x16 wall/visited bitmap, walking from (0,0) to
// (GOAL_X,GOAL_Y). Build macro MAZE_STEP_COUNT_EN adds the stepCount output.
//
// state  | meaning
// IDLE   | waiting for start
// CHK0   | reading start cell (0,0)
// CHK0W  | start-cell data back; blocked -> FAIL, else mark it
// TEST   | goal check, then probe neighbour for dir (or skip if off-grid)
// WAIT   | probe data back; blocked -> next dir, open -> ADV
// ADV    | push current cell, mark neighbour, move into it
// BACK   | all dirs tried: pop to parent, or FAIL if stack empty
// DONE   | goal reached, done held
// FAIL   | no path, fail held
//
// Strobes are registered from the next-state values so each one lines up
// with the state it belongs to; the read issued on entry to a probing TEST
// returns its data in the following WAIT. The (0,0) mark can only be decided
// in CHK0W, so it lands in the first TEST cycle, which therefore does not
// probe (tracked by mark).
module maze_dfs_ctrl
    import maze_pkg::*;
#(
    parameter int COORD_W = MAZE_COORD_W,
    parameter int GOAL_X  = 15,
    parameter int GOAL_Y  = 15
)(
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic               done,
    output logic               fail,
    output logic [COORD_W-1:0] memX,
    output logic [COORD_W-1:0] memY,
    output logic               memRd,
    output logic               memWr,
    input  logic               memDataIn,
    output logic               stkPush,
    output logic               stkPop,
    output logic [COORD_W-1:0] stkXIn,
    output logic [COORD_W-1:0] stkYIn,
    input  logic [COORD_W-1:0] stkXOut,
    input  logic [COORD_W-1:0] stkYOut,
    input  logic               stkEmpty
`ifdef MAZE_STEP_COUNT_EN
    ,
    output logic [7:0]         stepCount
`endif
);

    localparam logic [COORD_W-1:0] GOAL_XC = COORD_W'(GOAL_X);
    localparam logic [COORD_W-1:0] GOAL_YC = COORD_W'(GOAL_Y);

    state_t             state, state_n;
    logic [COORD_W-1:0] cur_x, cur_y, cur_x_n, cur_y_n;
    logic [2:0]         dir, dir_n;
    logic               mark, mark_n;

    logic [COORD_W-1:0] now_x, now_y, nx_x, nx_y;
    logic               now_inb, nx_inb;
    logic               at_goal, goal_n, probe_n, mark_wr;

    maze_nbr_calc #(.COORD_W(COORD_W)) u_nbr_now (
        .cur_x     (cur_x),
        .cur_y     (cur_y),
        .dir       (dir[1:0]),
        .nbr_x     (now_x),
        .nbr_y     (now_y),
        .in_bounds (now_inb)
    );

    maze_nbr_calc #(.COORD_W(COORD_W)) u_nbr_next (
        .cur_x     (cur_x_n),
        .cur_y     (cur_y_n),
        .dir       (dir_n[1:0]),
        .nbr_x     (nx_x),
        .nbr_y     (nx_y),
        .in_bounds (nx_inb)
    );

    assign at_goal = (cur_x == GOAL_XC) && (cur_y == GOAL_YC);
    assign goal_n  = (cur_x_n == GOAL_XC) && (cur_y_n == GOAL_YC);
    assign probe_n = (state_n == S_TEST) && !mark_n && !goal_n && !dir_n[2] && nx_inb;
    assign mark_wr = (state == S_CHK0W) && (state_n == S_TEST);

    // next state, position and direction
    always_comb begin
        state_n = state;
        cur_x_n = cur_x;
        cur_y_n = cur_y;
        dir_n   = dir;
        mark_n  = mark;
        case (state)
            S_IDLE, S_DONE, S_FAIL: begin
                if (start) state_n = S_CHK0;
            end
            S_CHK0: state_n = S_CHK0W;
            S_CHK0W: begin
                if (memDataIn) begin
                    state_n = S_FAIL;
                end else begin
                    state_n = S_TEST;
                    cur_x_n = '0;
                    cur_y_n = '0;
                    dir_n   = 3'd0;
                    mark_n  = 1'b1;
                end
            end
            S_TEST: begin
                if (at_goal)       state_n = S_DONE;
                else if (mark)     mark_n  = 1'b0;
                else if (dir[2])   state_n = S_BACK;
                else if (!now_inb) dir_n   = dir + 3'd1;
                else               state_n = S_WAIT;
            end
            S_WAIT: begin
                if (memDataIn) begin
                    dir_n   = dir + 3'd1;
                    state_n = S_TEST;
                end else begin
                    state_n = S_ADV;
                end
            end
            S_ADV: begin
                cur_x_n = now_x;
                cur_y_n = now_y;
                dir_n   = 3'd0;
                state_n = S_TEST;
            end
            S_BACK: begin
                if (stkEmpty) begin
                    state_n = S_FAIL;
                end else begin
                    cur_x_n = stkXOut;
                    cur_y_n = stkYOut;
                    dir_n   = 3'd0;
                    state_n = S_TEST;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // state register and registered strobes/addresses
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            cur_x   <= '0;
            cur_y   <= '0;
            dir     <= 3'd0;
            mark    <= 1'b0;
            done    <= 1'b0;
            fail    <= 1'b0;
            memX    <= '0;
            memY    <= '0;
            memRd   <= 1'b0;
            memWr   <= 1'b0;
            stkPush <= 1'b0;
            stkPop  <= 1'b0;
            stkXIn  <= '0;
            stkYIn  <= '0;
        end else begin
            state   <= state_n;
            cur_x   <= cur_x_n;
            cur_y   <= cur_y_n;
            dir     <= dir_n;
            mark    <= mark_n;
            done    <= (state_n == S_DONE);
            fail    <= (state_n == S_FAIL);
            memRd   <= (state_n == S_CHK0) || probe_n;
            memWr   <= mark_wr || (state_n == S_ADV);
            stkPush <= (state_n == S_ADV);
            stkPop  <= (state_n == S_BACK) && !stkEmpty;
            if ((state_n == S_CHK0) || mark_wr) begin
                memX <= '0;
                memY <= '0;
            end else if (probe_n) begin
                memX <= nx_x;
                memY <= nx_y;
            end
            if (state_n == S_ADV) begin
                stkXIn <= cur_x;
                stkYIn <= cur_y;
            end
        end
    end

`ifdef MAZE_STEP_COUNT_EN
    logic start_acc;
    assign start_acc = start && ((state == S_IDLE) || (state == S_DONE) || (state == S_FAIL));

    // stack depth tracker, saturating at both ends
    always_ff @(posedge clk) begin
        if (rst || start_acc) begin
            stepCount <= 8'd0;
        end else if (stkPush && (stepCount != 8'hFF)) begin
            stepCount <= stepCount + 8'd1;
        end else if (stkPop && (stepCount != 8'd0)) begin
            stepCount <= stepCount - 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_maze_dfs_ctrl.sv
// tb_maze_dfs_ctrl: self-checking bench for maze_dfs_ctrl with memory and
// stack responders and an abstract DFS reference model.
module tb_maze_dfs_ctrl;

    logic       clk = 1'b0;
    logic       rst, start;
    logic       done, fail, memRd, memWr, stkPush, stkPop, stkEmpty;
    logic       memDataIn = 1'b0;
    logic [3:0] memX, memY, stkXIn, stkYIn, stkXOut, stkYOut;
`ifdef MAZE_STEP_COUNT_EN
    logic [7:0] stepCount;
`endif

    always #5 clk = ~clk;

    maze_dfs_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .done      (done),
        .fail      (fail),
        .memX      (memX),
        .memY      (memY),
        .memRd     (memRd),
        .memWr     (memWr),
        .memDataIn (memDataIn),
        .stkPush   (stkPush),
        .stkPop    (stkPop),
        .stkXIn    (stkXIn),
        .stkYIn    (stkYIn),
        .stkXOut   (stkXOut),
        .stkYOut   (stkYOut),
        .stkEmpty  (stkEmpty)
`ifdef MAZE_STEP_COUNT_EN
        ,
        .stepCount (stepCount)
`endif
    );

    // ---------------- environment: maze memory and coordinate stack
    logic       wall [16][16];
    logic       mem  [16][16];
    logic [3:0] stk_x [256];
    logic [3:0] stk_y [256];
    int         sp = 0;
    logic       load_req = 1'b0;
    logic [7:0] act_push[$];
    int         act_pops = 0;
    int         violations = 0;

    assign stkEmpty = (sp == 0);
    assign stkXOut  = (sp > 0) ? stk_x[8'(sp - 1)] : 4'd0;
    assign stkYOut  = (sp > 0) ? stk_y[8'(sp - 1)] : 4'd0;

    always @(posedge clk) begin
        if (load_req) begin
            for (int x = 0; x < 16; x++)
                for (int y = 0; y < 16; y++)
                    mem[x][y] <= wall[x][y];
            sp <= 0;
            act_push.delete();
            act_pops   <= 0;
            violations <= 0;
        end else begin
            if (memRd) memDataIn <= mem[memX][memY];
            if (memWr) mem[memX][memY] <= 1'b1;
            if (stkPush && sp < 256) begin
                stk_x[8'(sp)] <= stkXIn;
                stk_y[8'(sp)] <= stkYIn;
                sp <= sp + 1;
                act_push.push_back({stkXIn, stkYIn});
            end
            if (stkPop) begin
                if (sp > 0) sp <= sp - 1;
                act_pops <= act_pops + 1;
            end
            if ((memRd && memWr) || (stkPush && stkPop) || (stkPop && stkEmpty) ||
                (stkPush && done) || (stkPush && !memWr) || (memRd && (stkPush || stkPop)) ||
                (memWr && stkPop))
                violations <= violations + 1;
        end
    end

    // ---------------- checking helpers
    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_maze();
        load_req = 1'b1;
        tick();
        load_req = 1'b0;
    endtask

    task automatic build_maze(input int id);
        for (int x = 0; x < 16; x++)
            for (int y = 0; y < 16; y++)
                wall[x][y] = (id == 99) ? ($urandom_range(99) < 30) : 1'b0;
        case (id)
            1: wall[0][0] = 1'b1;
            2: begin wall[1][0] = 1'b1; wall[0][1] = 1'b1; end
            3: begin wall[3][0] = 1'b1; wall[2][1] = 1'b1; wall[1][1] = 1'b1; end
            99: begin
                if ($urandom_range(9) != 0) wall[0][0] = 1'b0;
                wall[15][15] = 1'b0;
            end
            default: ;
        endcase
    endtask

    // ---------------- reference model: plain DFS over the wall grid,
    // first unvisited neighbour in order right, down, left, up
    logic [7:0] exp_push[$];

    task automatic ref_model(output bit r_done, output int r_pops, output int r_depth);
        bit vis [16][16];
        int dx[4] = '{1, 0, -1, 0};
        int dy[4] = '{0, 1, 0, -1};
        int cx, cy, nx, ny;
        int path_x[$], path_y[$];
        bit found;
        exp_push.delete();
        r_done = 0; r_pops = 0; r_depth = 0;
        for (int x = 0; x < 16; x++)
            for (int y = 0; y < 16; y++)
                vis[x][y] = wall[x][y];
        if (vis[0][0]) return;
        vis[0][0] = 1; cx = 0; cy = 0; nx = 0; ny = 0;
        forever begin
            if (cx == 15 && cy == 15) begin r_done = 1; break; end
            found = 0;
            for (int d = 0; d < 4 && !found; d++) begin
                nx = cx + dx[d];
                ny = cy + dy[d];
                if (nx >= 0 && nx < 16 && ny >= 0 && ny < 16 && !vis[nx][ny]) found = 1;
            end
            if (found) begin
                exp_push.push_back({cx[3:0], cy[3:0]});
                path_x.push_back(cx);
                path_y.push_back(cy);
                vis[nx][ny] = 1;
                cx = nx; cy = ny;
            end else if (path_x.size() == 0) begin
                break;
            end else begin
                cx = path_x.pop_back();
                cy = path_y.pop_back();
                r_pops++;
            end
        end
        r_depth = path_x.size();
    endtask

    typedef struct {
        int maze;
        bit e_done;
        bit e_fail;
        int e_push;
        int e_pop;
        int e_depth;
    } vec_t;

    task automatic run_search(input bit pulse, input int mid, output bit timed_out);
        int n;
        if (pulse) begin
            start = 1'b1;
            tick();
            start = 1'b0;
        end
        n = 1;
        while (!(done || fail) && n < 20000) begin
            start = (n == mid);
            tick();
            n++;
        end
        start = 1'b0;
        timed_out = !(done || fail);
    endtask

    task automatic check_run(input string nm, input bit pulse, input int mid,
                             input bit use_tab, input vec_t v_in);
        vec_t v;
        bit   td, m_done;
        int   m_pops, m_depth, mism;
        v = v_in;
        ref_model(m_done, m_pops, m_depth);
        if (!use_tab) begin
            v.e_done  = m_done;
            v.e_fail  = !m_done;
            v.e_push  = exp_push.size();
            v.e_pop   = m_pops;
            v.e_depth = m_depth;
        end
        run_search(pulse, mid, td);
        chk({nm, "_timeout"}, int'(td), 0);
        chk({nm, "_done"}, int'(done), int'(v.e_done));
        chk({nm, "_fail"}, int'(fail), int'(v.e_fail));
        chk({nm, "_pushes"}, act_push.size(), v.e_push);
        chk({nm, "_pops"}, act_pops, v.e_pop);
        chk({nm, "_depth"}, sp, v.e_depth);
        mism = 0;
        for (int i = 0; i < exp_push.size(); i++)
            if (i >= act_push.size() || act_push[i] != exp_push[i]) mism++;
        chk({nm, "_push_seq_errs"}, mism, 0);
        chk({nm, "_protocol_errs"}, violations, 0);
`ifdef MAZE_STEP_COUNT_EN
        chk({nm, "_steps"}, int'(stepCount), v.e_depth);
`endif
    endtask

    // ---------------- main sequence
    vec_t tab[4];
    vec_t dummy;

    initial begin
        tab[0] = '{0, 1'b1, 1'b0, 30, 0, 30};
        tab[1] = '{1, 1'b0, 1'b1, 0, 0, 0};
        tab[2] = '{2, 1'b0, 1'b1, 0, 0, 0};
        tab[3] = '{3, 1'b1, 1'b0, 32, 2, 30};
        dummy  = '{0, 1'b0, 1'b0, 0, 0, 0};

        rst = 1'b1; start = 1'b0;
        build_maze(0);
        load_maze();
        tick(); tick();
        rst = 1'b0;
        chk("rst_flags", int'({done, fail, memRd, memWr, stkPush, stkPop}), 0);
        chk("rst_mem_addr", int'({memX, memY}), 0);
        chk("rst_stk_data", int'({stkXIn, stkYIn}), 0);

        // blocked start cell: read (0,0) first, fail on the 3rd cycle
        build_maze(1);
        load_maze();
        start = 1'b1; tick(); start = 1'b0;
        chk("blk_chk0_rd", int'(memRd), 1);
        chk("blk_chk0_addr", int'({memX, memY}), 0);
        tick();
        chk("blk_fail_early", int'(fail), 0);
        tick();
        chk("blk_fail_3rd", int'(fail), 1);
        chk("blk_no_push", act_push.size(), 0);

        // test-plan mazes
        for (int i = 0; i < 4; i++) begin
            build_maze(tab[i].maze);
            load_maze();
            check_run($sformatf("plan%0d", i), 1'b1, -1, 1'b1, tab[i]);
        end

        // start in DONE restarts; start during TEST is ignored
        build_maze(0);
        load_maze();
        check_run("pre_done", 1'b1, -1, 1'b0, dummy);
        build_maze(0);
        load_maze();
        start = 1'b1; tick(); start = 1'b0;
        chk("restart_done_drop", int'(done), 0);
        chk("restart_rd", int'(memRd), 1);
        chk("restart_addr", int'({memX, memY}), 0);
        check_run("start_in_test", 1'b0, 3, 1'b0, dummy);

        // reset during WAIT aborts at once
        build_maze(0);
        load_maze();
        start = 1'b1; tick(); start = 1'b0;
        tick(); tick(); tick();
        chk("probe_rd", int'(memRd), 1);
        chk("probe_addr", int'({memX, memY}), 8'h10);
        tick();
        rst = 1'b1; tick(); rst = 1'b0;
        chk("mid_rst_flags", int'({done, fail, memRd, memWr, stkPush, stkPop}), 0);
        chk("mid_rst_addr", int'({memX, memY, stkXIn, stkYIn}), 0);
        build_maze(3);
        load_maze();
        check_run("after_rst", 1'b1, -1, 1'b0, dummy);

        // random mazes against the model
        for (int r = 0; r < 6; r++) begin
            build_maze(99);
            load_maze();
            check_run($sformatf("rand%0d", r), 1'b1, -1, 1'b0, dummy);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/maze_dfs_ctrl.md
Name: maze_dfs_ctrl

Overview:
- Depth-first-search controller for the 4-bit-coordinate maze solver.
- Sequences the coordinate stack and a 16x16 single-bit maze memory.
- Walks from (0,0) to a goal cell and marks visited cells in memory.
- On success the stack holds the path from start to goal. On dead-end exhaustion it raises fail.

Parameters:
- COORD_W, 4, coordinate width for X and Y.
- GOAL_X, 15, goal column.
- GOAL_Y, 15, goal row.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a search; honoured only in IDLE, DONE or FAIL.
- done  out  1  level; goal reached.
- fail  out  1  level; no path exists.
- memX  out  COORD_W  maze cell column address.
- memY  out  COORD_W  maze cell row address.
- memRd  out  1  read strobe.
- memWr  out  1  write strobe; always writes 1 (marks the cell visited).
- memDataIn  in  1  read data, valid the cycle after memRd. 1 = wall or visited, 0 = open.
- stkPush  out  1  push {stkXIn, stkYIn}.
- stkPop  out  1  pop top entry.
- stkXIn  out  COORD_W  push X.
- stkYIn  out  COORD_W  push Y.
- stkXOut  in  COORD_W  top-of-stack X, combinational.
- stkYOut  in  COORD_W  top-of-stack Y, combinational.
- stkEmpty  in  1  stack holds no entries.

Behaviour:
Reset:
- rst synchronous, active-high, one clock, single clock domain.
- All outputs 0. curX = curY = 0. dir = 0. State = IDLE.
- rst mid-search aborts immediately; memory and stack contents are not cleared by this block.

States:
- IDLE: wait for start, then go to CHK0.
- CHK0: read (0,0): memRd=1, memX=memY=0.
- CHK0W: if memDataIn=1, go to FAIL (start cell blocked). Otherwise write (0,0) (memWr=1) and go to TEST.
- TEST: if (curX,curY) == (GOAL_X,GOAL_Y), go to DONE. Otherwise compute neighbour for dir: 0=right(X+1), 1=down(Y+1), 2=left(X-1), 3=up(Y-1).
  - Neighbour out of bounds (X/Y = 0 decrement or max increment, no wrap-around): dir++ and stay in TEST.
  - In bounds: assert memRd with the neighbour address, go to WAIT.
- WAIT: if memDataIn=1, dir++ and go to TEST. Otherwise go to ADV.
- ADV, single cycle, all at once:
  - stkPush=1 with {curX,curY}.
  - memWr=1 at the neighbour address.
  - cur <= neighbour, dir <= 0, go to TEST.
- TEST with dir exhausted (dir was 3 and failed): go to BACK.
- BACK:
  - If stkEmpty, go to FAIL.
  - Otherwise cur <= {stkXOut, stkYOut}, stkPop=1, dir <= 0, go to TEST. Visited marks prevent revisits.
- DONE: done=1 (held). On start, clear done and go to CHK0.
- FAIL: fail=1 (held). On start, clear fail and go to CHK0.

Timing and protocol rules:
- Strobes (memRd, memWr, stkPush, stkPop) are registered single-cycle pulses; never two at once except memWr with stkPush in ADV.
- stkPush and stkPop are mutually exclusive.
- Latency: 2 cycles per probed neighbour, 1 cycle per ADV, 1 cycle per BACK.
- Goal equal to (0,0): done 3 cycles after start (CHK0, CHK0W, TEST).
- start while searching is ignored.
- No pop is ever issued when stkEmpty=1, and no push is issued after done.

Optional Feature:
- Macro MAZE_STEP_COUNT_EN.
- Defined:
  - Adds output stepCount [7:0]: +1 on each push, -1 on each pop.
  - Cleared on rst and on accepted start.
  - Equals path length when done.
  - Saturates at 255 with no wrap.
- Undefined: port absent; no counter logic.

Decomposition:
- Package maze_pkg holds:
  - State enum (IDLE, CHK0, CHK0W, TEST, WAIT, ADV, BACK, DONE, FAIL).
  - Direction constants DIR_R=0, DIR_D=1, DIR_L=2, DIR_U=3.
  - COORD_W default.
- One sub-module, maze_nbr_calc: combinational; inputs cur and dir; outputs neighbour X/Y and inBounds.

Test Plan:
1. All-open maze, goal (15,15) -> path goes right along row 0 to (15,0), then down. done after 30 ADVs. 30 pushes, 0 pops. stepCount=30.
2. Wall at (0,0) -> fail=1 on 3rd cycle after start. No stkPush ever asserted.
3. Cell (0,0) enclosed: walls at (1,0) and (0,1) -> four probes (two skipped as out of bounds), BACK sees stkEmpty=1, fail=1. Zero pushes and pops.
4. Dead-end corridor: open (1,0),(2,0); wall (3,0),(2,1),(1,1); open (0,1) and downward -> two pops back to (0,0), then advance down. Check the stack never underflows. Reaching the goal raises done.
5. rst pulsed during WAIT -> next cycle all outputs 0 and state IDLE. A new start runs normally (memory pre-cleared by the bench).
6. start pulsed in DONE -> done drops next cycle and CHK0 read issued at (0,0). start pulsed during TEST -> no effect.
